// File: rtl/ser_out_tx.sv
// rtl/ser_out_tx.sv - FIFO-buffered UART-style serial transmitter, MSB first.
// Optional even-parity bit between data and stop: define TX_PARITY_EN.
module ser_out_tx #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 8
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic [DATA_W-1:0]             Din,
    input  logic                          DinValid,
    output logic                          DinReady,
    input  logic [DIV_W-1:0]              ConfigDiv,
    output logic                          TxOut,
    output logic                          TxBusy,
    output logic                          TxDone,
    output logic [$clog2(FIFO_DEPTH):0]   FifoLevel
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DIV_W-1:0]  div_q, div_d, div_lat_q, div_lat_d;
    logic              tx_q, tx_d, busy_q, busy_d, done_q, done_d;
    logic              push, pop, bit_end, load;
`ifdef TX_PARITY_EN
    logic              par_q, par_d;
`endif

    assign DinReady  = (level_q != LW'(FIFO_DEPTH));
    assign FifoLevel = level_q;
    assign TxOut     = tx_q;
    assign TxBusy    = busy_q;
    assign TxDone    = done_q;

    always_comb begin
        push      = DinValid && DinReady;
        pop       = 1'b0;
        load      = 1'b0;
        bit_end   = (div_q == div_lat_q);
        state_d   = state_q;
        shreg_d   = shreg_q;
        idx_d     = idx_q;
        div_lat_d = div_lat_q;
        div_d     = div_q;
`ifdef TX_PARITY_EN
        par_d     = par_q;
`endif
        if (state_q != ST_IDLE) begin
            div_d = bit_end ? '0 : div_q + DIV_W'(1);
        end

        case (state_q)
            ST_IDLE:  load = (level_q != '0);
            ST_START: if (bit_end) state_d = ST_DATA;
            ST_DATA: begin
                if (bit_end) begin
                    if (idx_q == '0) begin
`ifdef TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d   = idx_q - IW'(1);
                        shreg_d = shreg_q << 1;
                    end
                end
            end
`ifdef TX_PARITY_EN
            ST_PARITY: if (bit_end) state_d = ST_STOP;
`endif
            ST_STOP: begin
                if (bit_end) begin
                    if (level_q != '0) load = 1'b1;
                    else               state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Frame start: pop head word and freeze the bit rate for this frame.
        if (load) begin
            pop       = 1'b1;
            shreg_d   = mem_q[rd_ptr_q];
            idx_d     = IW'(DATA_W - 1);
            div_d     = '0;
            div_lat_d = ConfigDiv;
            state_d   = ST_START;
`ifdef TX_PARITY_EN
            par_d     = ^mem_q[rd_ptr_q];
`endif
        end

        wr_ptr_d = wr_ptr_q + (push ? AW'(1) : AW'(0));
        rd_ptr_d = rd_ptr_q + (pop ? AW'(1) : AW'(0));
        level_d  = level_q + (push ? LW'(1) : LW'(0)) - (pop ? LW'(1) : LW'(0));

        // Line outputs are registered, so derive them from the next state.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shreg_d[DATA_W-1];
`ifdef TX_PARITY_EN
            ST_PARITY: tx_d = par_d;
`endif
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_STOP) && (div_d == div_lat_d);
    end

    always_ff @(posedge Clk) begin
        if (push) mem_q[wr_ptr_q] <= Din;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            idx_q     <= '0;
            div_q     <= '0;
            div_lat_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            idx_q     <= idx_d;
            div_q     <= div_d;
            div_lat_q <= div_lat_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end
endmodule

// File: tb/tb_ser_out_tx.sv
// tb/tb_ser_out_tx.sv - scoreboard bench for ser_out_tx with a bit-level frame model.
`timescale 1ns/1ps
module tb_ser_out_tx;
    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int DIV_W      = 8;
`ifdef TX_PARITY_EN
    localparam int NB = DATA_W + 3;
`else
    localparam int NB = DATA_W + 2;
`endif

    logic              Clk = 1'b0;
    logic              Reset = 1'b0;
    logic [DATA_W-1:0] Din = '0;
    logic              DinValid = 1'b0;
    logic              DinReady;
    logic [DIV_W-1:0]  ConfigDiv = 8'd1;
    logic              TxOut, TxBusy, TxDone;
    logic [$clog2(FIFO_DEPTH):0] FifoLevel;

    ser_out_tx #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
        .Clk(Clk), .Reset(Reset), .Din(Din), .DinValid(DinValid), .DinReady(DinReady),
        .ConfigDiv(ConfigDiv), .TxOut(TxOut), .TxBusy(TxBusy), .TxDone(TxDone),
        .FifoLevel(FifoLevel)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [DATA_W-1:0] word;
        int                period;
    } exp_t;

    exp_t sb[$];
    logic bits[$];
    int   checks = 0;
    int   errors = 0;
    bit   b2b_en = 0;
    bit   prev_done = 0;

    // Frame position k: 0 start, 1..DATA_W data MSB first, then parity (optional), then stop.
    function automatic logic exp_bit(input logic [DATA_W-1:0] w, input int k);
        if (k == 0) return 1'b0;
        if (k <= DATA_W) return logic'((w >> (DATA_W - k)) & 1);
`ifdef TX_PARITY_EN
        if (k == DATA_W + 1) return logic'($countones(w) % 2);
`endif
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_frame();
        exp_t e;
        int   bad = 0;
        int   first_bad = -1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame actual_len=%0d required=no frame", bits.size());
            return;
        end
        e = sb.pop_front();
        check("frame_len", 64'(bits.size()), 64'(NB * e.period));
        for (int k = 0; k < NB; k++) begin
            for (int j = 0; j < e.period; j++) begin
                int p = k * e.period + j;
                if (p < bits.size() && bits[p] !== exp_bit(e.word, k)) begin
                    bad++;
                    if (first_bad < 0) first_bad = p;
                end
            end
        end
        if (bad != 0) begin
            errors++;
            $display("FAIL frame_bits word=%h actual_bad_samples=%0d (first at %0d) required=0",
                     e.word, bad, first_bad);
        end
    endtask

    always @(negedge Clk) begin
        if (!Reset) begin
            bits.delete();
            prev_done = 0;
        end else begin
            if (b2b_en && prev_done && sb.size() > 0) check("back_to_back_busy", 64'(TxBusy), 64'd1);
            prev_done = 0;
            if (TxBusy) begin
                bits.push_back(TxOut);
                if (bits.size() > NB * 300) begin
                    check("frame_runaway_len", 64'(bits.size()), 64'(NB * 300));
                    bits.delete();
                end
            end
            if (TxDone) begin
                check_frame();
                bits.delete();
                prev_done = 1;
            end
        end
    end

    task automatic push_word(input logic [DATA_W-1:0] w, input int per);
        exp_t e;
        int   n = 0;
        @(negedge Clk);
        Din = w;
        DinValid = 1'b1;
        while (!DinReady && n < 2000) begin
            @(negedge Clk);
            n++;
        end
        if (!DinReady) begin
            check("push_timeout_ready", 64'(DinReady), 64'd1);
            DinValid = 1'b0;
            return;
        end
        @(posedge Clk);
        e.word = w;
        e.period = per;
        sb.push_back(e);
    endtask

    task automatic end_push();
        @(negedge Clk);
        DinValid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge Clk);
        while ((TxBusy || FifoLevel != 0 || sb.size() != 0) && n < 20000) begin
            @(negedge Clk);
            n++;
        end
        check("idle_pending_frames", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int bad;
        logic [DATA_W-1:0] w;
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        logic [DATA_W-1:0] w;

        repeat (3) @(negedge Clk);
        check("rst_txout", 64'(TxOut), 64'd1);
        check("rst_busy", 64'(TxBusy), 64'd0);
        check("rst_done", 64'(TxDone), 64'd0);
        check("rst_ready", 64'(DinReady), 64'd1);
        check("rst_level", 64'(FifoLevel), 64'd0);
        Reset = 1'b1;

        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (TxOut !== 1'b1 || TxBusy !== 1'b0 || DinReady !== 1'b1 || FifoLevel !== 0) bad++;
        end
        check("idle_100_bad_cycles", 64'(bad), 64'd0);

        ConfigDiv = 8'd1;
        push_word(32'h0000_0002, 2);
        end_push();
        check("level_after_push", 64'(FifoLevel), 64'd1);
        wait_idle();

        ConfigDiv = 8'd0;
        b2b_en = 1;
        for (int i = 1; i <= 6; i++) begin
            push_word({8{4'(i)}}, 1);
            if (i == 5) begin
                @(negedge Clk);
                check("burst_level_full", 64'(FifoLevel), 64'(FIFO_DEPTH));
                check("burst_ready_low", 64'(DinReady), 64'd0);
            end
        end
        end_push();
        wait_idle();
        b2b_en = 0;

        ConfigDiv = 8'd1;
        push_word(32'hDEAD_BEEF, 2);
        push_word(32'h1234_5678, 4);
        end_push();
        repeat (10) @(negedge Clk);
        ConfigDiv = 8'd3;
        wait_idle();

        ConfigDiv = 8'd1;
        push_word(32'hA5A5_F00F, 2);
        push_word(32'h0F0F_0F0F, 2);
        end_push();
        repeat (12) @(negedge Clk);
        #2 Reset = 1'b0;
        #1;
        check("abort_txout", 64'(TxOut), 64'd1);
        check("abort_busy", 64'(TxBusy), 64'd0);
        check("abort_level", 64'(FifoLevel), 64'd0);
        check("abort_ready", 64'(DinReady), 64'd1);
        check("abort_done", 64'(TxDone), 64'd0);
        sb.delete();
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge Clk);
            if (TxBusy !== 1'b0 || TxDone !== 1'b0 || TxOut !== 1'b1) bad++;
        end
        check("post_abort_quiet_cycles", 64'(bad), 64'd0);

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                wait_idle();
                ConfigDiv = 8'($urandom_range(0, 3));
            end
            w = $urandom;
            push_word(w, int'(ConfigDiv) + 1);
            end_push();
            repeat ($urandom_range(0, 40)) @(negedge Clk);
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
